// File: rtl/ifetch_prefetch.sv
// Instruction fetch unit: drives a 1-cycle synchronous ROM and buffers
// fetched {pc, inst} pairs in a small circular prefetch queue.
module ifetch_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 14,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [XLEN-1:0]          rom_data,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [XLEN-1:0]          if_pc,
    output logic [XLEN-1:0]          if_inst,
    output logic                     fetch_fault,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] tag_pc;
    logic            pending;
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] inst_q [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic            push;
    logic            pop;

    // Reserve a slot for the in-flight fetch so its response always fits.
    assign inflight = count + CW'(pending);

    assign rom_en = rst && !fetch_fault && !redirect_valid
                    && (inflight < CW'(DEPTH));
    assign rom_addr = fetch_pc[ADDR_W+1:2];

    assign push = pending;
    assign pop  = if_valid && if_ready;

    assign if_valid  = (count != '0);
    assign if_pc     = if_valid ? pc_q[rd_ptr]   : '0;
    assign if_inst   = if_valid ? inst_q[rd_ptr] : '0;
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            tag_pc      <= '0;
            pending     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            pending <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            if (redirect_pc[1]) begin
                fetch_fault <= 1'b1;
            end else begin
                fetch_pc    <= redirect_pc & ~XLEN'(1);
                fetch_fault <= 1'b0;
            end
        end else begin
            pending <= rom_en;
            if (rom_en) begin
                tag_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only visible while count > 0.
    always_ff @(posedge clk) begin
        if (rst && !redirect_valid && push) begin
            pc_q[wr_ptr]   <= tag_pc;
            inst_q[wr_ptr] <= rom_data;
        end
    end

endmodule
